// File: rtl/acc_bank.sv
// Multi-lane signed accumulator bank: one start-sampled run of cfg_len input beats,
// with per-lane saturate/wrap on overflow and a held result until the downstream accepts it.

module acc_lane #(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 24,
  parameter int SATURATE  = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clr_sat,
  input  logic                        load,
  input  logic                        add,
  input  logic signed [IN_WIDTH-1:0]  din,
  output logic [OUT_WIDTH-1:0]        acc,
  output logic                        sat
);
  localparam logic signed [OUT_WIDTH-1:0] MAX_V = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [OUT_WIDTH-1:0] MIN_V = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  logic signed [OUT_WIDTH-1:0] acc_q, acc_d, din_ext;
  logic signed [OUT_WIDTH:0]   sum;
  logic                        ovf, sat_q, sat_d;

  assign din_ext = (OUT_WIDTH)'(din);
  // One guard bit: the sum overflowed iff the top two bits disagree.
  assign sum     = {acc_q[OUT_WIDTH-1], acc_q} + {din_ext[OUT_WIDTH-1], din_ext};
  assign ovf     = sum[OUT_WIDTH] ^ sum[OUT_WIDTH-1];

  always_comb begin
    acc_d = acc_q;
    sat_d = sat_q;
    if (clr_sat) sat_d = 1'b0;
    if (load) begin
      acc_d = din_ext;
    end else if (add) begin
      acc_d = sum[OUT_WIDTH-1:0];
      if (ovf) begin
        sat_d = 1'b1;
        if (SATURATE != 0) acc_d = sum[OUT_WIDTH] ? MIN_V : MAX_V;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
      sat_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      sat_q <= sat_d;
    end
  end

  assign acc = acc_q;
  assign sat = sat_q;
endmodule

module acc_bank #(
  parameter int NUM_LANES = 4,
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 24,
  parameter int LEN_WIDTH = 8,
  parameter int SATURATE  = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [LEN_WIDTH-1:0]            cfg_len,
  output logic                            busy,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_LANES*IN_WIDTH-1:0]   in,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_LANES*OUT_WIDTH-1:0]  out,
  output logic [NUM_LANES-1:0]            out_sat
);
  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

  localparam logic [LEN_WIDTH-1:0] ONE = 1;

  state_t                 state_q, state_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d, cnt_q, cnt_d;
  logic                   busy_q, busy_d, out_valid_q, out_valid_d;
  logic                   clr_sat, beat, first;

  logic [NUM_LANES-1:0][IN_WIDTH-1:0]  in_lanes;
  logic [NUM_LANES-1:0][OUT_WIDTH-1:0] acc_lanes;

  assign in_ready = (state_q == ACCUM);
  assign beat     = in_ready && in_valid;
  assign first    = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    clr_sat = 1'b0;
    unique case (state_q)
      IDLE: if (start && cfg_len != '0) begin
        state_d = ACCUM;
        len_d   = cfg_len;
        cnt_d   = '0;
        clr_sat = 1'b1;
      end
      // cnt_q counts beats already taken, so it never exceeds len-1 here and cannot wrap.
      ACCUM: if (in_valid) begin
        cnt_d = cnt_q + ONE;
        if (cnt_q == len_q - ONE) state_d = DRAIN;
      end
      DRAIN: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d      = (state_d != IDLE);
    out_valid_d = (state_d == DRAIN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_lanes = in;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    acc_lane #(
      .IN_WIDTH (IN_WIDTH),
      .OUT_WIDTH(OUT_WIDTH),
      .SATURATE (SATURATE)
    ) u_lane (
      .clk    (clk),
      .reset  (reset),
      .clr_sat(clr_sat),
      .load   (beat && first),
      .add    (beat && !first),
      .din    (in_lanes[g]),
      .acc    (acc_lanes[g]),
      .sat    (out_sat[g])
    );
  end

  assign out       = acc_lanes;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
endmodule

// File: tb/tb_acc_bank.sv
// Bench for acc_bank: three instances (24-bit saturating, 8-bit saturating, 8-bit wrapping)
// share one stimulus; results are checked against an integer reference model and fixed vectors.

module tb_acc_bank;
  logic        clk = 1'b0;
  logic        reset, start, in_valid, out_ready;
  logic [7:0]  cfg_len;
  logic [31:0] in_bus;

  logic [95:0] out_a;
  logic [31:0] out_b, out_c;
  logic [3:0]  sat_a, sat_b, sat_c;
  logic        busy_a, busy_b, busy_c, ir_a, ir_b, ir_c, ov_a, ov_b, ov_c;

  int n_cmp = 0, n_bad = 0;
  int bx[0:255][0:3];

  always #5 clk = ~clk;

  acc_bank u_a (.clk(clk), .reset(reset), .start(start), .cfg_len(cfg_len), .busy(busy_a),
    .in_valid(in_valid), .in_ready(ir_a), .in(in_bus), .out_valid(ov_a), .out_ready(out_ready),
    .out(out_a), .out_sat(sat_a));
  acc_bank #(.OUT_WIDTH(8), .SATURATE(1)) u_b (.clk(clk), .reset(reset), .start(start),
    .cfg_len(cfg_len), .busy(busy_b), .in_valid(in_valid), .in_ready(ir_b), .in(in_bus),
    .out_valid(ov_b), .out_ready(out_ready), .out(out_b), .out_sat(sat_b));
  acc_bank #(.OUT_WIDTH(8), .SATURATE(0)) u_c (.clk(clk), .reset(reset), .start(start),
    .cfg_len(cfg_len), .busy(busy_c), .in_valid(in_valid), .in_ready(ir_c), .in(in_bus),
    .out_valid(ov_c), .out_ready(out_ready), .out(out_c), .out_sat(sat_c));

  task automatic chk(input string nm, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, got, exp);
    end
  endtask

  function automatic longint la(input int i); return longint'($signed(out_a[i*24 +: 24])); endfunction
  function automatic longint lb(input int i); return longint'($signed(out_b[i*8 +: 8])); endfunction
  function automatic longint lc(input int i); return longint'($signed(out_c[i*8 +: 8])); endfunction

  // Reference: integer running sum with range test per beat, clamp or modular reduction.
  function automatic void ref_acc(input int lane, input int n, input int ow, input bit satm,
                                  output longint v, output bit s);
    longint mx, mn, t, m;
    m  = longint'(1) <<< ow;
    mx = (m / 2) - 1;
    mn = -(m / 2);
    v = 0; s = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (k == 0) v = bx[k][lane];
      else begin
        t = v + bx[k][lane];
        if (t > mx || t < mn) begin
          s = 1'b1;
          if (satm) v = (t > mx) ? mx : mn;
          else begin
            v = t & (m - 1);
            if (v > mx) v = v - m;
          end
        end else v = t;
      end
    end
  endfunction

  task automatic check_model(input int n, input string tag);
    longint v; bit s;
    for (int i = 0; i < 4; i++) begin
      ref_acc(i, n, 24, 1'b1, v, s);
      chk($sformatf("%s a.lane%0d", tag, i), la(i), v);
      chk($sformatf("%s a.sat%0d", tag, i), sat_a[i], s);
      ref_acc(i, n, 8, 1'b1, v, s);
      chk($sformatf("%s b.lane%0d", tag, i), lb(i), v);
      chk($sformatf("%s b.sat%0d", tag, i), sat_b[i], s);
      ref_acc(i, n, 8, 1'b0, v, s);
      chk($sformatf("%s c.lane%0d", tag, i), lc(i), v);
      chk($sformatf("%s c.sat%0d", tag, i), sat_c[i], s);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, " out_a"}, longint'(out_a != '0), 0);
    chk({tag, " out_bc"}, longint'((out_b | out_c) != '0), 0);
    chk({tag, " sat"}, sat_a | sat_b | sat_c, 0);
    chk({tag, " busy"}, busy_a | busy_b | busy_c, 0);
    chk({tag, " in_ready"}, ir_a | ir_b | ir_c, 0);
    chk({tag, " out_valid"}, ov_a | ov_b | ov_c, 0);
  endtask

  // One complete run: start, beats per valid pattern (or random gaps/starts), DRAIN hold, handshake.
  task automatic run(input int len, input bit [15:0] vpat, input int vplen, input bit rnd,
                     input int hold);
    int k = 0, t = 0, cyc = 0;
    bit v;
    logic [95:0] sa;
    logic [31:0] sb, sc;
    start = 1'b1; cfg_len = len[7:0]; in_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    while (k < len && cyc < 4000) begin
      v = rnd ? ($urandom_range(0, 3) != 0) : ((vplen == 0) ? 1'b1 : vpat[t % vplen]);
      t++;
      in_valid = v;
      for (int i = 0; i < 4; i++) in_bus[i*8 +: 8] = v ? bx[k][i][7:0] : 8'($urandom);
      if (rnd) begin start = 1'($urandom_range(0, 1)); cfg_len = 8'($urandom); end
      @(negedge clk);
      chk("accum in_ready", ir_a & ir_b & ir_c, 1);
      chk("accum out_valid", ov_a | ov_b | ov_c, 0);
      @(posedge clk); #1;
      if (v) k++;
      cyc++;
    end
    chk("beats sent", k, len);
    start = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("drain out_valid", ov_a & ov_b & ov_c, 1);
    chk("drain in_ready", ir_a | ir_b | ir_c, 0);
    chk("drain busy", busy_a & busy_b & busy_c, 1);
    check_model(len, "drain");
    sa = out_a; sb = out_b; sc = out_c;
    repeat (hold) begin
      @(posedge clk); #1;
      start = 1'($urandom_range(0, 1)); cfg_len = 8'($urandom);
      in_valid = 1'($urandom_range(0, 1)); in_bus = $urandom;
      @(negedge clk);
      chk("hold stable", longint'(out_a == sa && out_b == sb && out_c == sc), 1);
      chk("hold out_valid", ov_a & ov_b & ov_c, 1);
      chk("hold in_ready", ir_a | ir_b | ir_c, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1; start = 1'b1; cfg_len = 8'd5; in_valid = 1'b1;
    @(negedge clk);
    chk("handshake out_valid", ov_a & ov_b & ov_c, 1);
    @(posedge clk); #1;
    out_ready = 1'b0; start = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("post busy", busy_a | busy_b | busy_c, 0);
    chk("post out_valid", ov_a | ov_b | ov_c, 0);
    chk("post retain", longint'(out_a == sa && out_b == sb && out_c == sc), 1);
  endtask

  typedef struct {
    int     len;
    int     lane;
    int     b0, b1, b2;
    longint e_a, e_b, e_c;
    bit     s_a, s_bc;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[4];
    tbl[0] = '{3, 0,    5,   -2,    7,   10,   10,   10, 1'b0, 1'b0};
    tbl[1] = '{3, 1,  100,  100,  100,  300,  127,   44, 1'b0, 1'b1};
    tbl[2] = '{3, 1, -100, -100, -100, -300, -128,  -44, 1'b0, 1'b1};
    tbl[3] = '{3, 2,  127,    1,   -1,  127,  126,  127, 1'b0, 1'b1};

    reset = 1'b1; start = 1'b0; cfg_len = '0; in_valid = 1'b0; in_bus = '0; out_ready = 1'b0;
    #12;
    chk_idle_zero("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 3; k++) for (int i = 0; i < 4; i++) bx[k][i] = 0;
      bx[0][tbl[r].lane] = tbl[r].b0;
      bx[1][tbl[r].lane] = tbl[r].b1;
      bx[2][tbl[r].lane] = tbl[r].b2;
      run(tbl[r].len, '0, 0, 1'b0, r);
      chk($sformatf("vec%0d a", r), la(tbl[r].lane), tbl[r].e_a);
      chk($sformatf("vec%0d b", r), lb(tbl[r].lane), tbl[r].e_b);
      chk($sformatf("vec%0d c", r), lc(tbl[r].lane), tbl[r].e_c);
      chk($sformatf("vec%0d sat a", r), sat_a, longint'(tbl[r].s_a) << tbl[r].lane);
      chk($sformatf("vec%0d sat b", r), sat_b, longint'(tbl[r].s_bc) << tbl[r].lane);
      chk($sformatf("vec%0d sat c", r), sat_c, longint'(tbl[r].s_bc) << tbl[r].lane);
    end

    // Gapped valid 1,0,0,1,1,0,1 with a long DRAIN hold.
    for (int k = 0; k < 4; k++) for (int i = 0; i < 4; i++) bx[k][i] = 1;
    run(4, 16'b1011001, 7, 1'b0, 5);
    for (int i = 0; i < 4; i++) chk($sformatf("gap lane%0d", i), la(i), 4);

    // Zero-length start is ignored.
    start = 1'b1; cfg_len = 8'd0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("len0 busy", busy_a | busy_b | busy_c, 0);
    chk("len0 in_ready", ir_a | ir_b | ir_c, 0);

    // Random runs with random gaps and stray starts during ACCUM.
    for (int r = 0; r < 20; r++) begin
      int len;
      len = $urandom_range(1, 12);
      for (int k = 0; k < len; k++)
        for (int i = 0; i < 4; i++)
          bx[k][i] = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) != 0) ? 127 : -128)
                                                  : $urandom_range(0, 255) - 128;
      run(len, '0, 0, 1'b1, $urandom_range(0, 3));
    end

    // Maximum length run.
    for (int k = 0; k < 255; k++) for (int i = 0; i < 4; i++) bx[k][i] = $urandom_range(0, 255) - 128;
    run(255, '0, 0, 1'b0, 2);

    // Asynchronous reset after 2 of 4 beats, then a clean length-1 run.
    start = 1'b1; cfg_len = 8'd4;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; in_bus = {4{8'd50}};
    repeat (2) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    #2;
    chk("pre-reset lane0", la(0), 100);
    reset = 1'b1;
    #1;
    chk_idle_zero("async reset");
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("after reset out_valid", ov_a | ov_b | ov_c, 0);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) bx[0][i] = 9;
    run(1, '0, 0, 1'b0, 0);
    for (int i = 0; i < 4; i++) chk($sformatf("no residue lane%0d", i), la(i), 9);
    chk("no residue sat", sat_a | sat_b | sat_c, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
